// File: rtl/l2cache_ctrl_nway_if.sv
// Request/memory-side bundle for the N-way L2 cache controller.
// The controller takes the slave view; the requester/datapath model takes the master view.
interface l2cache_ctrl_nway_if #(
  parameter int WAYS = 4,
  parameter int SETS = 16
);
  localparam int IDX_W = $clog2(SETS);

  logic             mem_read;
  logic             mem_write;
  logic             mem_resp;
  logic [IDX_W-1:0] set_idx;
  logic [WAYS-1:0]  way_hit;
  logic [WAYS-1:0]  way_valid;
  logic [WAYS-1:0]  way_dirty;
  logic [WAYS-1:0]  way_sel;
  logic             load_data;
  logic             load_tag;
  logic             dirty_set;
  logic             dirty_clr;
  logic             wb_addr_sel;
  logic             pmem_read;
  logic             pmem_write;
  logic             pmem_resp;

  modport master (
    output mem_read, mem_write, set_idx, way_hit, way_valid, way_dirty, pmem_resp,
    input  mem_resp, way_sel, load_data, load_tag, dirty_set, dirty_clr,
           wb_addr_sel, pmem_read, pmem_write
  );

  modport slave (
    input  mem_read, mem_write, set_idx, way_hit, way_valid, way_dirty, pmem_resp,
    output mem_resp, way_sel, load_data, load_tag, dirty_set, dirty_clr,
           wb_addr_sel, pmem_read, pmem_write
  );
endinterface

// File: rtl/l2cache_ctrl_nway.sv
// N-way set-associative write-back L2 controller with per-set tree pseudo-LRU.
// Define L2CTRL_PERF_CNT_EN to add the hit/miss/writeback counter ports.
module l2cache_ctrl_nway #(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  l2cache_ctrl_nway_if.slave      bus
`ifdef L2CTRL_PERF_CNT_EN
  ,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt,
  output logic [31:0]             wb_cnt
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, WB, FILL} state_e;

  state_e           state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [IDX_W-1:0] vset_q, vset_d;
  logic [WAYS-2:0]  plru_q [SETS];

  logic             plru_wr;
  logic [IDX_W-1:0] plru_idx;
  logic [WAY_W-1:0] plru_way;
  logic [WAYS-2:0]  plru_row_d;

  logic             req, hit_any, inv_any;
  logic [WAY_W-1:0] hit_way, inv_way, pick_way;

  logic            mem_resp, load_data, load_tag, dirty_set, dirty_clr;
  logic            wb_addr_sel, pmem_read, pmem_write;
  logic [WAYS-1:0] way_sel;

  // Lowest set bit wins: multiple hits are illegal, and the lowest free way is refilled first.
  function automatic logic [WAY_W-1:0] lowest_set(input logic [WAYS-1:0] v);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) idx = WAY_W'(i);
    end
    return idx;
  endfunction

  // Walk the tree from the root; each bit names the half holding the victim.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [WAYS-1:0]  r;
    logic [WAY_W-1:0] node, way;
    logic             b;
    r    = {1'b0, bits};
    node = '0;
    way  = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b    = r[node];
      way  = WAY_W'({way, b});
      node = WAY_W'({node, 1'b1} + {{WAY_W{1'b0}}, b});
    end
    return way;
  endfunction

  // Point every node on the accessed way's path away from it.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-1:0]  r;
    logic [WAY_W-1:0] node, sh;
    logic             dir;
    r    = {1'b0, bits};
    node = '0;
    for (int l = 0; l < WAY_W; l++) begin
      sh      = way << l;
      dir     = sh[WAY_W-1];
      r[node] = ~dir;
      node    = WAY_W'({node, 1'b1} + {{WAY_W{1'b0}}, dir});
    end
    return r[WAYS-2:0];
  endfunction

  assign req      = bus.mem_read | bus.mem_write;
  assign hit_any  = |bus.way_hit;
  assign inv_any  = ~&bus.way_valid;
  assign hit_way  = lowest_set(bus.way_hit);
  assign inv_way  = lowest_set(~bus.way_valid);
  assign pick_way = inv_any ? inv_way : plru_victim(plru_q[bus.set_idx]);

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d     = state_q;
    victim_d    = victim_q;
    vset_d      = vset_q;
    plru_wr     = 1'b0;
    plru_idx    = bus.set_idx;
    plru_way    = hit_way;
    mem_resp    = 1'b0;
    load_data   = 1'b0;
    load_tag    = 1'b0;
    dirty_set   = 1'b0;
    dirty_clr   = 1'b0;
    wb_addr_sel = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    way_sel     = '0;

    // Outputs are combinational, so they are gated while reset is held.
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (req && hit_any) begin
            mem_resp  = 1'b1;
            way_sel   = {{(WAYS-1){1'b0}}, 1'b1} << hit_way;
            load_data = bus.mem_write;
            dirty_set = bus.mem_write;
            plru_wr   = 1'b1;
          end else if (req) begin
            victim_d = pick_way;
            vset_d   = bus.set_idx;
            state_d  = (bus.way_valid[pick_way] && bus.way_dirty[pick_way]) ? WB : FILL;
          end
        end
        WB: begin
          pmem_write  = 1'b1;
          wb_addr_sel = 1'b1;
          way_sel     = {{(WAYS-1){1'b0}}, 1'b1} << victim_q;
          if (bus.pmem_resp) begin
            dirty_clr = 1'b1;
            state_d   = req ? FILL : IDLE;
          end
        end
        FILL: begin
          pmem_read = 1'b1;
          way_sel   = {{(WAYS-1){1'b0}}, 1'b1} << victim_q;
          if (bus.pmem_resp) begin
            load_data = 1'b1;
            load_tag  = 1'b1;
            dirty_clr = 1'b1;
            plru_wr   = 1'b1;
            plru_idx  = vset_q;
            plru_way  = victim_q;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign plru_row_d = plru_touch(plru_q[plru_idx], plru_way);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      victim_q <= '0;
      vset_q   <= '0;
      // NOTE: the PLRU array is flop-based and must start cleared, so it is reset like any register.
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q  <= state_d;
      victim_q <= victim_d;
      vset_q   <= vset_d;
      if (plru_wr) plru_q[plru_idx] <= plru_row_d;
    end
  end

  assign bus.mem_resp    = mem_resp;
  assign bus.way_sel     = way_sel;
  assign bus.load_data   = load_data;
  assign bus.load_tag    = load_tag;
  assign bus.dirty_set   = dirty_set;
  assign bus.dirty_clr   = dirty_clr;
  assign bus.wb_addr_sel = wb_addr_sel;
  assign bus.pmem_read   = pmem_read;
  assign bus.pmem_write  = pmem_write;

`ifdef L2CTRL_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic [31:0] wb_cnt_q, wb_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (state_q == IDLE && mem_resp) hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == IDLE && state_d != IDLE) miss_cnt_d = miss_cnt_q + 32'd1;
    if (state_q == WB && bus.pmem_resp && rst_n) wb_cnt_d = wb_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif
endmodule

// File: tb/tb_l2cache_ctrl_nway.sv
// Directed bench for l2cache_ctrl_nway (WAYS=4, SETS=16): expected hit responses are
// queued when a request is driven and compared when mem_resp appears.
module tb_l2cache_ctrl_nway;
  localparam int WAYS = 4;
  localparam int SETS = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct {
    logic [31:0] way_sel;
    logic [31:0] load_data;
    logic [31:0] dirty_set;
  } exp_t;

  exp_t sb[$];

  l2cache_ctrl_nway_if #(.WAYS(WAYS), .SETS(SETS)) bus ();

`ifdef L2CTRL_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  l2cache_ctrl_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef L2CTRL_PERF_CNT_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Wait (bounded) for mem_resp, then compare against the oldest queued expectation.
  task automatic wait_resp(input string tag, input int budget);
    int   n;
    exp_t e;
    n = 0;
    smp();
    while (bus.mem_resp !== 1'b1 && n < budget) begin
      smp();
      n++;
    end
    check({tag, "_resp"}, 32'(bus.mem_resp), 1);
    check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_way_sel"},   32'(bus.way_sel),   e.way_sel);
      check({tag, "_load_data"}, 32'(bus.load_data), e.load_data);
      check({tag, "_dirty_set"}, 32'(bus.dirty_set), e.dirty_set);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n         = 1'b0;
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b0;
    bus.set_idx   = 4'd1;
    bus.way_hit   = 4'b0100;
    bus.way_valid = 4'b1111;
    bus.way_dirty = 4'b0000;
    bus.pmem_resp = 1'b0;

    // Held in reset with a hitting request: every output stays low.
    smp();
    check("rst_mem_resp", 32'(bus.mem_resp), 0);
    check("rst_way_sel", 32'(bus.way_sel), 0);
    check("rst_pmem_read", 32'(bus.pmem_read), 0);
    check("rst_pmem_write", 32'(bus.pmem_write), 0);
`ifdef L2CTRL_PERF_CNT_EN
    check("rst_hit_cnt", hit_cnt, 0);
`endif
    #2 rst_n = 1'b1;

    // Read hit in set 1, way 2: same-cycle response, no data load.
    sb.push_back('{32'h4, 32'h0, 32'h0});
    wait_resp("rd_hit", 0);

    // Write hit in set 0, way 0: load + dirty strobes; set 0 PLRU now points at way 2.
    cyc();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b1;
    bus.set_idx   = 4'd0;
    bus.way_hit   = 4'b0001;
    sb.push_back('{32'h1, 32'h1, 32'h1});
    wait_resp("wr_hit", 0);

    // Clean miss in set 0, all valid: PLRU victim is way 2, straight to FILL.
    cyc();
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b1;
    bus.way_hit   = 4'b0000;
    smp();
    check("plru_idle_resp", 32'(bus.mem_resp), 0);
    check("plru_idle_pmem_read", 32'(bus.pmem_read), 0);
    cyc();
    smp();
    check("plru_fill_read", 32'(bus.pmem_read), 1);
    check("plru_fill_write", 32'(bus.pmem_write), 0);
    check("plru_fill_sel", 32'(bus.way_sel), 32'h4);
    cyc();
    bus.pmem_resp = 1'b1;
    smp();
    check("plru_fill_load_tag", 32'(bus.load_tag), 1);
    check("plru_fill_load_data", 32'(bus.load_data), 1);
    check("plru_fill_dirty_clr", 32'(bus.dirty_clr), 1);
    cyc();
    bus.pmem_resp = 1'b0;
    bus.way_hit   = 4'b0100;
    sb.push_back('{32'h4, 32'h0, 32'h0});
    wait_resp("plru_refill_hit", 0);

    // Miss in set 3 with way 2 invalid (dirty bit ignored for an invalid way).
    cyc();
    bus.set_idx   = 4'd3;
    bus.way_hit   = 4'b0000;
    bus.way_valid = 4'b1011;
    bus.way_dirty = 4'b1111;
    smp();
    check("inv_idle_write", 32'(bus.pmem_write), 0);
    cyc();
    for (int i = 0; i < 5; i++) begin
      smp();
      check("inv_fill_read", 32'(bus.pmem_read), 1);
      check("inv_fill_write", 32'(bus.pmem_write), 0);
      check("inv_fill_sel", 32'(bus.way_sel), 32'h4);
      check("inv_fill_load_tag", 32'(bus.load_tag), 0);
      cyc();
    end
    bus.pmem_resp = 1'b1;
    smp();
    check("inv_resp_load_tag", 32'(bus.load_tag), 1);
    check("inv_resp_sel", 32'(bus.way_sel), 32'h4);
    cyc();
    bus.pmem_resp = 1'b0;
    bus.way_valid = 4'b1111;
    bus.way_dirty = 4'b0000;
    bus.way_hit   = 4'b0100;
    sb.push_back('{32'h4, 32'h0, 32'h0});
    wait_resp("inv_hit", 0);

    // Dirty miss in fresh set 5: PLRU victim way 0 is dirty -> WB then FILL.
    cyc();
    bus.set_idx   = 4'd5;
    bus.way_hit   = 4'b0000;
    bus.way_dirty = 4'b0001;
    smp();
    check("dm_idle_write", 32'(bus.pmem_write), 0);
    cyc();
    smp();
    check("dm_wb_write", 32'(bus.pmem_write), 1);
    check("dm_wb_read", 32'(bus.pmem_read), 0);
    check("dm_wb_addr_sel", 32'(bus.wb_addr_sel), 1);
    check("dm_wb_sel", 32'(bus.way_sel), 32'h1);
    check("dm_wb_dirty_clr", 32'(bus.dirty_clr), 0);
    cyc();
    bus.pmem_resp = 1'b1;
    smp();
    check("dm_wb_resp_dirty_clr", 32'(bus.dirty_clr), 1);
    check("dm_wb_resp_load_tag", 32'(bus.load_tag), 0);
    cyc();
    bus.pmem_resp = 1'b0;
    bus.way_dirty = 4'b0000;
    smp();
    check("dm_fill_read", 32'(bus.pmem_read), 1);
    check("dm_fill_write", 32'(bus.pmem_write), 0);
    check("dm_fill_addr_sel", 32'(bus.wb_addr_sel), 0);
    check("dm_fill_sel", 32'(bus.way_sel), 32'h1);
    cyc();
    bus.pmem_resp = 1'b1;
    smp();
    check("dm_fill_load_tag", 32'(bus.load_tag), 1);
    cyc();
    bus.pmem_resp = 1'b0;
    bus.way_hit   = 4'b0001;
    sb.push_back('{32'h1, 32'h0, 32'h0});
    wait_resp("dm_hit", 0);
`ifdef L2CTRL_PERF_CNT_EN
    check("dm_wb_cnt", wb_cnt, 1);
    check("dm_miss_cnt", miss_cnt, 3);
`endif

    // Dirty miss in set 6 with the request dropped mid-WB: no FILL follows.
    cyc();
    bus.set_idx   = 4'd6;
    bus.way_hit   = 4'b0000;
    bus.way_dirty = 4'b0001;
    cyc();
    smp();
    check("drop_wb_write", 32'(bus.pmem_write), 1);
    cyc();
    bus.mem_read = 1'b0;
    smp();
    check("drop_wb_held", 32'(bus.pmem_write), 1);
    check("drop_wb_no_read", 32'(bus.pmem_read), 0);
    cyc();
    bus.pmem_resp = 1'b1;
    smp();
    check("drop_wb_dirty_clr", 32'(bus.dirty_clr), 1);
    cyc();
    bus.pmem_resp = 1'b0;
    bus.way_dirty = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      smp();
      check("drop_idle_read", 32'(bus.pmem_read), 0);
      check("drop_idle_write", 32'(bus.pmem_write), 0);
      cyc();
    end
`ifdef L2CTRL_PERF_CNT_EN
    check("drop_wb_cnt", wb_cnt, 2);
`endif

    // Clean miss in set 0 (PLRU victim way 1), then async reset mid-FILL.
    bus.set_idx  = 4'd0;
    bus.mem_read = 1'b1;
    smp();
    cyc();
    smp();
    check("arst_fill_read", 32'(bus.pmem_read), 1);
    check("arst_fill_sel", 32'(bus.way_sel), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_read_drop", 32'(bus.pmem_read), 0);
    check("arst_sel_drop", 32'(bus.way_sel), 0);
    smp();
    #2 rst_n = 1'b1;
    cyc();
    smp();
    check("arst_refill_read", 32'(bus.pmem_read), 1);
    check("arst_plru_cleared_sel", 32'(bus.way_sel), 32'h1);
`ifdef L2CTRL_PERF_CNT_EN
    check("arst_wb_cnt", wb_cnt, 0);
`endif
    cyc();
    bus.pmem_resp = 1'b1;
    smp();
    check("arst_fill_load_tag", 32'(bus.load_tag), 1);
    cyc();
    bus.pmem_resp = 1'b0;
    bus.way_hit   = 4'b0001;
    sb.push_back('{32'h1, 32'h0, 32'h0});
    wait_resp("arst_hit", 0);

    // Stray pmem_resp in IDLE is ignored.
    cyc();
    bus.mem_read  = 1'b0;
    bus.way_hit   = 4'b0000;
    bus.pmem_resp = 1'b1;
    smp();
    check("idle_stray_dirty_clr", 32'(bus.dirty_clr), 0);
    check("idle_stray_load_tag", 32'(bus.load_tag), 0);
    cyc();
    bus.pmem_resp = 1'b0;
    smp();
    check("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
